lcd_bus_sched: RTL and testbench
================================

# lcd_bus_sched

Timed bus scheduler for the 8-bit HD44780-style character LCD: shares the LCD bus between two requesters (index 0 = init/command engine, index 1 = text updater), arbitrates round-robin with an optional lock for atomic multi-byte sequences, and drives LCD_E/LCD_RS/LCD_DATA with programmable setup, enable-high, hold and command-execution delays.

- Sits between the LCD content/command logic and the panel pins.
- Replaces ad-hoc E toggling with cycle-counted timing derived from CLK.

## Interface
- POWERUP_CYC, 750000: cycles after reset before the first transfer (15 ms at 50 MHz).
- SETUP_CYC, 2: cycles RS/DATA are stable before E rises; must be ≥1.
- E_HIGH_CYC, 12: cycles E is high; must be ≥1.
- HOLD_CYC, 1: cycles RS/DATA are held after E falls; must be ≥1.
- SHORT_WAIT_CYC, 1850: execution wait for normal commands and data (37 µs).
- LONG_WAIT_CYC, 76000: execution wait for clear/home (1.52 ms).
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester transfer request; held until accepted.
- req_rs  in  2  per-requester RS value (0 = command, 1 = data).
- req_data  in  16  per-requester byte; requester i uses bits [8i+7:8i].
- req_lock  in  2  keep grant after this transfer.
- req_ready  out  2  combinational accept strobe; transfer occurs on valid & ready.
- busy  out  1  high in every state except IDLE.
- grant  out  2  one-hot owner of the last accepted transfer; 00 after reset.
- LCD_E  out  1  enable strobe (registered).
- LCD_RS  out  1  register select (registered).
- LCD_DATA  out  8  data bus (registered).

## Operation
- States: POWERUP, IDLE, SETUP, EHIGH, HOLD, WAIT.
- POWERUP: count POWERUP_CYC cycles, then go to IDLE. All req_ready are 0.
- IDLE: select a requester.
  - If locked, only the lock owner can be selected. The other requester waits even if valid.
  - Otherwise, if both are valid, pick the one not in grant. If grant is 00, requester 0 wins.
  - If only one is valid, pick it.
  - req_ready[sel] = 1 only when in IDLE and req_valid[sel] = 1.
- On accept:
  - Latch rs and data into LCD_RS/LCD_DATA.
  - Update grant.
  - Set the lock to req_lock[sel]: lock=1 locks to sel, lock=0 releases.
  - Go to SETUP.
- SETUP (SETUP_CYC cycles) → EHIGH (E_HIGH_CYC cycles, LCD_E = 1) → HOLD (HOLD_CYC cycles) → WAIT → IDLE.
- WAIT length:
  - LONG_WAIT_CYC when rs = 0 and data ∈ {0x01, 0x02, 0x03} (clear / return home).
  - SHORT_WAIT_CYC otherwise.
  - A WAIT of 0 cycles skips directly to IDLE.
- LCD_RS/LCD_DATA keep their last value in IDLE/WAIT. They change only on accept.
- Counter: single down-counter sized $clog2 of the largest parameter plus 1. It is loaded on each state entry.
- Reset values:
  - LCD_E = 0, LCD_RS = 0, LCD_DATA = 0x00.
  - grant = 00, lock clear, busy = 1, state POWERUP.
- Reset mid-operation: LCD_E falls asynchronously and the full POWERUP_CYC delay restarts. Partial transfers are lost and not replayed.
- A locked owner that never sends a lock=0 transfer starves the other requester. This is a requester obligation and is not detected.

## Timing
- Accept at cycle 0 (IDLE). Cycle 1: LCD_RS/LCD_DATA show new values.
- LCD_E is high for cycles 1+S … S+E.
- Next accept is possible at cycle 1+S+E+H+W, where S/E/H/W are SETUP/E_HIGH/HOLD/WAIT counts.
- req_valid must not depend on req_ready. rs/data/lock must be stable while valid is high.
- First accept after reset deassertion happens no earlier than cycle POWERUP_CYC.

## Structure
- Package lcd_pkg holds:
  - State encoding.
  - Command constants: CMD_CLEAR 0x01, CMD_HOME 0x02, CMD_ENTRY 0x06, CMD_DISP_ON 0x0E, CMD_FUNC_8B2L 0x38.
  - Function is_long_cmd(rs, data).
- Sub-module lcd_rr_arb: 2-way round-robin with lock. Inputs are valid, lock, grant, idle; outputs are sel and ready.
- Timing FSM and counter live in lcd_bus_sched.

## Test plan
All scenarios use POWERUP=10, SETUP=2, E_HIGH=4, HOLD=1, SHORT=8, LONG=40.
- Reset, req_valid=01 from cycle 0 → req_ready stays 00 until cycle 10. Accept at cycle 10. LCD_E high for cycles 13–16, then LCD_E=0, LCD_RS=0, LCD_DATA=0x00 until the accept.
- Requester 1 sends rs=1 data 0x41 → LCD_DATA=0x41 and LCD_RS=1 from accept+1. LCD_E high 4 cycles. Next accept exactly 16 cycles after the first.
- Requester 0 sends rs=0 0x01, then 0x38 → gap between accepts is 48 cycles, then 16 cycles. rs=1 0x01 uses the 8-cycle wait.
- Both valid continuously, no lock → grants alternate 01, 10, 01, 10. First winner is requester 0.
- Requester 1 sends 3 bytes with lock=1,1,0 while requester 0 is valid → all 3 granted to requester 1 back-to-back, then requester 0.
- RST_N pulsed low during EHIGH → LCD_E=0 immediately. busy=1 and req_ready=00 for 10 cycles after release.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus scheduler: FSM state encoding,
// HD44780 command bytes and the long-execution command classifier.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_POWERUP = 3'd0,
      ST_IDLE    = 3'd1,
      ST_SETUP   = 3'd2,
      ST_EHIGH   = 3'd3,
      ST_HOLD    = 3'd4,
      ST_WAIT    = 3'd5
   } lcd_state_e;

   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   // The controller ignores bit 0 of return-home, so 0x03 is also a home command.
   localparam logic [7:0] CMD_HOME_ALT  = 8'h03;
   localparam logic [7:0] CMD_ENTRY     = 8'h06;
   localparam logic [7:0] CMD_DISP_ON   = 8'h0E;
   localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;

   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      logic long_s;
      long_s = 1'b0;
      if (!rs) begin
         case (data)
            CMD_CLEAR, CMD_HOME, CMD_HOME_ALT: long_s = 1'b1;
            default:                           long_s = 1'b0;
         endcase
      end else begin
         long_s = 1'b0;
      end
      return long_s;
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_rr_arb.sv
// Two-way round-robin requester selection with an ownership lock that pins
// the selection to the current grant holder for atomic multi-byte sequences.
module lcd_rr_arb
   import lcd_pkg::*;
(
   input  logic [1:0] valid_i,
   input  logic       lock_i,
   input  logic [1:0] grant_i,
   input  logic       idle_i,
   output logic       sel_o,
   output logic [1:0] ready_o
);

   // Selection priority: lock owner, then the requester not last granted, then whoever is valid.
   always_comb begin
      sel_o   = 1'b0;
      ready_o = 2'b00;
      if (lock_i) begin
         sel_o = grant_i[1];
      end else if (valid_i == 2'b11) begin
         sel_o = grant_i[0];
      end else if (valid_i[1]) begin
         sel_o = 1'b1;
      end else begin
         sel_o = 1'b0;
      end
      ready_o[1] = idle_i & valid_i[1] & sel_o;
      ready_o[0] = idle_i & valid_i[0] & ~sel_o;
   end

endmodule

// File: rtl/lcd_bus_sched.sv
// Timed LCD bus scheduler: arbitrates two requesters and sequences one
// setup / enable-high / hold / execution-wait frame per accepted byte.
module lcd_bus_sched
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYC    = 750000,
   parameter int SETUP_CYC      = 2,
   parameter int E_HIGH_CYC     = 12,
   parameter int HOLD_CYC       = 1,
   parameter int SHORT_WAIT_CYC = 1850,
   parameter int LONG_WAIT_CYC  = 76000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_rs,
   input  logic [15:0] req_data,
   input  logic [1:0]  req_lock,
   output logic [1:0]  req_ready,
   output logic        busy,
   output logic [1:0]  grant,
   output logic        LCD_E,
   output logic        LCD_RS,
   output logic [7:0]  LCD_DATA
);

   localparam int MAX_CYC = max_of(max_of(max_of(POWERUP_CYC, SETUP_CYC),
                                          max_of(E_HIGH_CYC, HOLD_CYC)),
                                   max_of(SHORT_WAIT_CYC, LONG_WAIT_CYC));
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;

   // A phase of n cycles loads n-1 and ends on the cycle the counter reads zero.
   function automatic logic [CNT_W-1:0] load_val(input int n);
      logic [CNT_W-1:0] v;
      if (n > 0) begin
         v = CNT_W'(n - 1);
      end else begin
         v = {CNT_W{1'b0}};
      end
      return v;
   endfunction

   localparam logic [CNT_W-1:0] PU_LD    = load_val(POWERUP_CYC);
   localparam logic [CNT_W-1:0] SETUP_LD = load_val(SETUP_CYC);
   localparam logic [CNT_W-1:0] EHIGH_LD = load_val(E_HIGH_CYC);
   localparam logic [CNT_W-1:0] HOLD_LD  = load_val(HOLD_CYC);
   localparam logic [CNT_W-1:0] SHORT_LD = load_val(SHORT_WAIT_CYC);
   localparam logic [CNT_W-1:0] LONG_LD  = load_val(LONG_WAIT_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic             SHORT_NONE = (SHORT_WAIT_CYC == 0);
   localparam logic             LONG_NONE  = (LONG_WAIT_CYC == 0);

   lcd_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       grant_q, grant_d;
   logic             lock_q, lock_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             lcd_e_q;
   logic             busy_q;

   logic             sel_s;
   logic [1:0]       ready_s;
   logic             accept_s;
   logic             cnt_zero_s;
   logic             wait_long_s;
   logic [7:0]       sel_data_s;

   lcd_rr_arb u_arb (
      .valid_i (req_valid),
      .lock_i  (lock_q),
      .grant_i (grant_q),
      .idle_i  (state_q == ST_IDLE),
      .sel_o   (sel_s),
      .ready_o (ready_s)
   );

   assign accept_s    = |(req_valid & ready_s);
   assign sel_data_s  = sel_s ? req_data[15:8] : req_data[7:0];
   assign cnt_zero_s  = (cnt_q == {CNT_W{1'b0}});
   assign wait_long_s = is_long_cmd(rs_q, data_q);

   // Next-state, counter reload and accept-time capture of the transfer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_zero_s ? cnt_q : (cnt_q - CNT_ONE);
      grant_d = grant_q;
      lock_d  = lock_q;
      rs_d    = rs_q;
      data_d  = data_q;
      case (state_q)
         ST_POWERUP: begin
            if (cnt_zero_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_POWERUP;
            end
         end
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_SETUP;
               cnt_d   = SETUP_LD;
               grant_d = sel_s ? 2'b10 : 2'b01;
               lock_d  = req_lock[sel_s];
               rs_d    = req_rs[sel_s];
               data_d  = sel_data_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (cnt_zero_s) begin
               state_d = ST_EHIGH;
               cnt_d   = EHIGH_LD;
            end else begin
               state_d = ST_SETUP;
            end
         end
         ST_EHIGH: begin
            if (cnt_zero_s) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               state_d = ST_EHIGH;
            end
         end
         ST_HOLD: begin
            if (cnt_zero_s) begin
               if (wait_long_s ? LONG_NONE : SHORT_NONE) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = wait_long_s ? LONG_LD : SHORT_LD;
               end
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_WAIT: begin
            if (cnt_zero_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_POWERUP;
            cnt_d   = PU_LD;
         end
      endcase
   end

   // State, counter and registered pin drive; reset drops LCD_E immediately.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_POWERUP;
         cnt_q   <= PU_LD;
         grant_q <= 2'b00;
         lock_q  <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         lcd_e_q <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         lock_q  <= lock_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         lcd_e_q <= (state_d == ST_EHIGH);
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   assign req_ready = ready_s;
   assign busy      = busy_q;
   assign grant     = grant_q;
   assign LCD_E     = lcd_e_q;
   assign LCD_RS    = rs_q;
   assign LCD_DATA  = data_q;

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Scoreboard bench for lcd_bus_sched: requester queues drive the bus, expected
// transfers are queued in grant order and checked at each LCD_E rising edge.
module tb_lcd_bus_sched;

   localparam int PU = 10;
   localparam int S  = 2;
   localparam int EH = 4;
   localparam int H  = 1;
   localparam int SW = 8;
   localparam int LW = 40;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [1:0]  req_valid;
   logic [1:0]  req_rs;
   logic [15:0] req_data;
   logic [1:0]  req_lock;
   logic [1:0]  req_ready;
   logic        busy;
   logic [1:0]  grant;
   logic        LCD_E;
   logic        LCD_RS;
   logic [7:0]  LCD_DATA;

   always #5 CLK = ~CLK;

   lcd_bus_sched #(
      .POWERUP_CYC(PU), .SETUP_CYC(S), .E_HIGH_CYC(EH), .HOLD_CYC(H),
      .SHORT_WAIT_CYC(SW), .LONG_WAIT_CYC(LW)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_rs(req_rs),
      .req_data(req_data), .req_lock(req_lock), .req_ready(req_ready),
      .busy(busy), .grant(grant), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_DATA(LCD_DATA)
   );

   typedef struct { logic rs; logic [7:0] data; logic lock; } xfer_t;
   typedef struct { int owner; logic rs; logic [7:0] data; } exp_t;

   xfer_t rq0[$];
   xfer_t rq1[$];
   exp_t  sb[$];
   int    acc_log[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    e_rise = 0;
   logic  e_prev = 1'b0;

   function automatic xfer_t mk(input logic rs, input logic [7:0] d, input logic lk);
      xfer_t x;
      x.rs = rs; x.data = d; x.lock = lk;
      return x;
   endfunction

   function automatic int exp_gap(input logic rs, input logic [7:0] d);
      logic lng;
      lng = (rs == 1'b0) && (d == 8'h01 || d == 8'h02 || d == 8'h03);
      return 1 + S + EH + H + (lng ? LW : SW);
   endfunction

   task automatic push_req(input int who, input logic rs, input logic [7:0] d, input logic lk);
      exp_t e;
      if (who == 1) rq1.push_back(mk(rs, d, lk));
      else          rq0.push_back(mk(rs, d, lk));
      e.owner = who; e.rs = rs; e.data = d;
      sb.push_back(e);
   endtask

   task automatic sample_and_drive();
      xfer_t f0, f1;
      exp_t  ex;
      int    last_acc;
      logic [1:0] g_exp;
      f0 = '{rs: 1'b0, data: 8'h00, lock: 1'b0};
      f1 = '{rs: 1'b0, data: 8'h00, lock: 1'b0};
      if (rq0.size() > 0) f0 = rq0[0];
      if (rq1.size() > 0) f1 = rq1[0];
      req_valid = {rq1.size() > 0, rq0.size() > 0};
      req_rs    = {f1.rs, f0.rs};
      req_data  = {f1.data, f0.data};
      req_lock  = {f1.lock, f0.lock};
      #1;
      if (req_valid[0] && req_ready[0]) begin acc_log.push_back(cyc); void'(rq0.pop_front()); end
      if (req_valid[1] && req_ready[1]) begin acc_log.push_back(cyc); void'(rq1.pop_front()); end
      if (LCD_E && !e_prev) begin
         e_rise   = cyc;
         last_acc = (acc_log.size() > 0) ? acc_log[$] : -1000;
         checks++;
         if (cyc != last_acc + 1 + S) begin
            failures++;
            $display("FAIL e_rise_time: rose at cycle %0d, required %0d", cyc, last_acc + 1 + S);
         end
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_xfer: rs=%0b data=%02h with empty scoreboard", LCD_RS, LCD_DATA);
         end else begin
            ex    = sb.pop_front();
            g_exp = (ex.owner == 1) ? 2'b10 : 2'b01;
            if ({LCD_RS, LCD_DATA, grant} !== {ex.rs, ex.data, g_exp}) begin
               failures++;
               $display("FAIL xfer_content: got rs=%0b data=%02h grant=%02b, required rs=%0b data=%02h grant=%02b",
                        LCD_RS, LCD_DATA, grant, ex.rs, ex.data, g_exp);
            end
         end
      end
      if (!LCD_E && e_prev) begin
         checks++;
         if (cyc - e_rise != EH) begin
            failures++;
            $display("FAIL e_width: high for %0d cycles, required %0d", cyc - e_rise, EH);
         end
      end
      e_prev = LCD_E;
   endtask

   task automatic step();
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      sample_and_drive();
   endtask

   task automatic apply_reset();
      @(negedge CLK);
      RST_N = 1'b0;
      rq0.delete(); rq1.delete(); sb.delete(); acc_log.delete();
      e_prev = 1'b0;
      req_valid = 2'b00; req_rs = 2'b00; req_data = 16'h0000; req_lock = 2'b00;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      cyc = 0;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((rq0.size() > 0 || rq1.size() > 0 || sb.size() > 0 || busy || LCD_E) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (rq0.size() > 0 || rq1.size() > 0 || sb.size() > 0 || busy || LCD_E) begin
         failures++;
         $display("FAIL %s_timeout: not drained after %0d cycles (pending %0d/%0d/%0d)",
                  name, budget, rq0.size(), rq1.size(), sb.size());
      end
   endtask

   task automatic check_powerup_window(input string name);
      for (int i = 0; i < PU; i++) begin
         checks++;
         if ({req_ready, busy, LCD_E, LCD_RS, LCD_DATA} !== {2'b00, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL %s_powerup: cycle %0d ready=%02b busy=%0b e=%0b rs=%0b data=%02h, required 00/1/0/0/00",
                     name, cyc, req_ready, busy, LCD_E, LCD_RS, LCD_DATA);
         end
         step();
      end
   endtask

   task automatic check_gaps(input string name);
      for (int i = 1; i < acc_log.size(); i++) begin
         checks++;
         if (acc_log[i] - acc_log[i-1] != 1 + S + EH + H + SW) begin
            failures++;
            $display("FAIL %s_gap%0d: %0d cycles, required %0d", name, i,
                     acc_log[i] - acc_log[i-1], 1 + S + EH + H + SW);
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      push_req(0, 1'b0, 8'h38, 1'b0);
      sample_and_drive();
      checks++;
      if ({LCD_E, LCD_RS, LCD_DATA, grant, busy} !== {1'b0, 1'b0, 8'h00, 2'b00, 1'b1}) begin
         failures++;
         $display("FAIL reset_state: e=%0b rs=%0b data=%02h grant=%02b busy=%0b, required 0/0/00/00/1",
                  LCD_E, LCD_RS, LCD_DATA, grant, busy);
      end
      check_powerup_window("reset");
      drain("reset", 100);
      checks++;
      if (acc_log.size() != 1 || acc_log[0] != PU) begin
         failures++;
         $display("FAIL reset_first_accept: %0d accepts, first at %0d, required one at %0d",
                  acc_log.size(), (acc_log.size() > 0) ? acc_log[0] : -1, PU);
      end
   endtask

   task automatic test_data_timing();
      acc_log.delete();
      push_req(1, 1'b1, 8'h41, 1'b0);
      push_req(1, 1'b1, 8'h42, 1'b0);
      drain("data", 100);
      checks++;
      if (acc_log.size() != 2) begin
         failures++;
         $display("FAIL data_accepts: %0d accepts, required 2", acc_log.size());
      end
      check_gaps("data");
      checks++;
      if ({LCD_RS, LCD_DATA, LCD_E} !== {1'b1, 8'h42, 1'b0}) begin
         failures++;
         $display("FAIL data_idle_hold: rs=%0b data=%02h e=%0b, required 1/42/0", LCD_RS, LCD_DATA, LCD_E);
      end
   endtask

   task automatic test_long_wait();
      xfer_t items[5];
      items[0] = mk(1'b0, 8'h01, 1'b0);
      items[1] = mk(1'b0, 8'h38, 1'b0);
      items[2] = mk(1'b1, 8'h01, 1'b0);
      items[3] = mk(1'b0, 8'h02, 1'b0);
      items[4] = mk(1'b0, 8'h06, 1'b0);
      acc_log.delete();
      foreach (items[i]) push_req(0, items[i].rs, items[i].data, 1'b0);
      drain("long", 400);
      checks++;
      if (acc_log.size() != 5) begin
         failures++;
         $display("FAIL long_accepts: %0d accepts, required 5", acc_log.size());
      end else begin
         for (int i = 1; i < 5; i++) begin
            checks++;
            if (acc_log[i] - acc_log[i-1] != exp_gap(items[i-1].rs, items[i-1].data)) begin
               failures++;
               $display("FAIL long_gap%0d: %0d cycles, required %0d", i,
                        acc_log[i] - acc_log[i-1], exp_gap(items[i-1].rs, items[i-1].data));
            end
         end
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         push_req(0, 1'b0, 8'h30 + 8'(i), 1'b0);
         push_req(1, 1'b1, 8'h61 + 8'(i), 1'b0);
      end
      sample_and_drive();
      drain("rr", 300);
      checks++;
      if (acc_log.size() != 8) begin
         failures++;
         $display("FAIL rr_accepts: %0d accepts, required 8", acc_log.size());
      end
      check_gaps("rr");
   endtask

   task automatic test_back_to_back_lock();
      acc_log.delete();
      push_req(0, 1'b1, 8'h50, 1'b0);
      push_req(1, 1'b1, 8'h4C, 1'b1);
      push_req(1, 1'b1, 8'h4D, 1'b1);
      push_req(1, 1'b1, 8'h4E, 1'b0);
      rq0.push_back(mk(1'b1, 8'h51, 1'b0));
      begin
         exp_t e;
         e.owner = 0; e.rs = 1'b1; e.data = 8'h51;
         sb.push_back(e);
      end
      drain("lock", 300);
      checks++;
      if (acc_log.size() != 5) begin
         failures++;
         $display("FAIL lock_accepts: %0d accepts, required 5", acc_log.size());
      end
      check_gaps("lock");
   endtask

   task automatic test_reset_mid();
      int n = 0;
      acc_log.delete();
      push_req(0, 1'b1, 8'h77, 1'b0);
      while (!LCD_E && n < 40) begin step(); n++; end
      checks++;
      if (!LCD_E) begin
         failures++;
         $display("FAIL midrst_reach_ehigh: LCD_E never rose within 40 cycles");
      end
      #1;
      RST_N = 1'b0;
      #1;
      checks++;
      if ({LCD_E, busy, req_ready} !== {1'b0, 1'b1, 2'b00}) begin
         failures++;
         $display("FAIL midrst_async: e=%0b busy=%0b ready=%02b, required 0/1/00", LCD_E, busy, req_ready);
      end
      apply_reset();
      push_req(0, 1'b0, 8'h0E, 1'b0);
      sample_and_drive();
      check_powerup_window("midrst");
      drain("midrst", 100);
      checks++;
      if (acc_log.size() != 1 || acc_log[0] != PU) begin
         failures++;
         $display("FAIL midrst_first_accept: %0d accepts, first at %0d, required one at %0d",
                  acc_log.size(), (acc_log.size() > 0) ? acc_log[0] : -1, PU);
      end
   endtask

   initial begin
      RST_N = 1'b0;
      req_valid = 2'b00; req_rs = 2'b00; req_data = 16'h0000; req_lock = 2'b00;
      test_reset();
      test_data_timing();
      test_long_wait();
      test_round_robin();
      test_back_to_back_lock();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
